// File: rtl/branch_stall_ctrl_pkg.sv
// Types shared by the branch stall sequencer and its bench-visible helpers.
// State values come from the shared codes.v so decode and control agree.
`include "codes.v"

package branch_stall_ctrl_pkg;

    // state | meaning
    // RUN      | fetch advancing, decode passes instructions
    // HOLD     | control transfer in execute, fetch frozen, bubbles injected
    // REDIRECT | one-cycle PC load from redirect_pc
    // ERROR    | resolve never arrived, sticky until reset_n
    typedef enum logic [1:0] {
        ST_RUN      = `STALL_RUN,
        ST_HOLD     = `STALL_HOLD,
        ST_REDIRECT = `STALL_REDIRECT,
        ST_ERROR    = `STALL_ERROR
    } stall_state_e;

endpackage

// File: rtl/codes.v
// Shared decode constants: RV32 control-transfer opcodes and the state
// encodings of the branch stall sequencer. Safe to include more than once.
`ifndef CODES_V
`define CODES_V

// Control-transfer opcodes that raise the decoder stall flag
`define OPC_BRANCH      7'b1100011
`define OPC_JAL         7'b1101111
`define OPC_JALR        7'b1100111

// branch_stall_ctrl state encodings
`define STALL_RUN       2'd0
`define STALL_HOLD      2'd1
`define STALL_REDIRECT  2'd2
`define STALL_ERROR     2'd3

`endif

// File: rtl/stall_perf_ctr.sv
// 32-bit wrapping event counter used for stall performance statistics.
module stall_perf_ctr (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Next count: add one per qualifying cycle, natural modulo-2^32 wrap
    always_comb begin
        count_d = count_q;
        if (inc_i) count_d = count_q + 32'd1;
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_stall_ctrl.sv
// Control-hazard sequencer between fetch and decode. Freezes fetch and
// squashes decode while a branch/jump resolves, then redirects or resumes.
// Optional statistics counters are built when STALL_PERF_EN is defined.
module branch_stall_ctrl
    import branch_stall_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int XLEN     = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall_in,
    input  logic            resolve_valid,
    input  logic            resolve_taken,
    input  logic [XLEN-1:0] resolve_target,
    output logic            fetch_en,
    output logic            bubble,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            err
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_taken
`endif
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    // JALR targets always land on an even address
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

    stall_state_e    state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            fetch_en_q, fetch_en_d;
    logic            bubble_q, bubble_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            err_q, err_d;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    // Next-state logic; resolve beats the timeout on the final HOLD cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (stall_in) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (resolve_valid)
                    state_d = resolve_taken ? ST_REDIRECT : ST_RUN;
                else if (wait_cnt_q == WAIT_LAST)
                    state_d = ST_ERROR;
            end
            ST_REDIRECT: state_d = ST_RUN;
            ST_ERROR:    state_d = ST_ERROR;
            default:     state_d = ST_RUN;
        endcase
    end

    // Next output values, derived from the state being entered so that every
    // output is registered with one cycle of latency from the sampled inputs
    always_comb begin
        wait_cnt_d       = '0;
        fetch_en_d       = (state_d == ST_RUN);
        bubble_d         = (state_d != ST_RUN);
        redirect_valid_d = (state_d == ST_REDIRECT);
        err_d            = (state_d == ST_ERROR);
        redirect_pc_d    = redirect_pc_q;
        // counter stays below MAX_WAIT because HOLD is left at WAIT_LAST
        if (state_q == ST_HOLD && state_d == ST_HOLD)
            wait_cnt_d = wait_cnt_q + 1'b1;
        if (state_q == ST_HOLD && state_d == ST_REDIRECT)
            redirect_pc_d = resolve_target & PC_ALIGN_MASK;
    end

    // Output and wait-counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q       <= '0;
            fetch_en_q       <= 1'b1;
            bubble_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            err_q            <= 1'b0;
        end else begin
            wait_cnt_q       <= wait_cnt_d;
            fetch_en_q       <= fetch_en_d;
            bubble_q         <= bubble_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            err_q            <= err_d;
        end
    end

    assign fetch_en       = fetch_en_q;
    assign bubble         = bubble_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign err            = err_q;

`ifdef STALL_PERF_EN
    logic inc_branch;
    logic inc_taken;

    assign inc_branch = (state_q == ST_RUN)  && (state_d == ST_HOLD);
    assign inc_taken  = (state_q == ST_HOLD) && (state_d == ST_REDIRECT);

    stall_perf_ctr u_stall_cycles (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (bubble_q),
        .count_o (perf_stall_cycles)
    );

    stall_perf_ctr u_branches (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (inc_branch),
        .count_o (perf_branches)
    );

    stall_perf_ctr u_taken (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (inc_taken),
        .count_o (perf_taken)
    );
`endif

endmodule
